local_bus_slave: RTL and testbench

LOCAL_BUS_SLAVE -- requirements
Module: local_bus_slave

---
 rtl/lbus_pkg.sv | 15 +
 rtl/lbus_sync_fifo.sv | 51 +++++
 rtl/local_bus_slave.sv | 95 +++++++++
 tb/tb_local_bus_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbus_pkg.sv
// Shared local-bus definitions used by both the slave and the bus master.
// Opcodes, bus width and the packed layout of one bus word.
package lbus_pkg;

    localparam logic [1:0] LBUS_OP_IDLE = 2'b00;
    localparam logic [1:0] LBUS_OP_WR   = 2'b01;
    localparam logic [1:0] LBUS_OP_RD   = 2'b10;
    localparam int         LBUS_DAT_W   = 10;

    typedef struct packed {
        logic [1:0] chl;
        logic [7:0] data;
    } lbus_word_t;

endpackage

// File: rtl/lbus_sync_fifo.sv
// Single-clock show-ahead FIFO; push/pop arrive already qualified by the caller.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module lbus_sync_fifo #(
    parameter int AW = 3,
    parameter int DW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          one_left_o
);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   fill;
    logic [DW-1:0] mem_q [2**AW];

    always_comb begin
        wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // A push while full only happens alongside a pop, so it overwrites the slot being vacated.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign fill       = wptr_q - rptr_q;
    assign rdata_o    = mem_q[rptr_q[AW-1:0]];
    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign one_left_o = (fill == {{AW{1'b0}}, 1'b1});

endmodule

// File: rtl/local_bus_slave.sv
// Local bus slave: queues outgoing bytes in a TX FIFO for the master to read
// and captures bytes the master writes into a one-cycle RX strobe.
module local_bus_slave
    import lbus_pkg::*;
#(
    parameter int TXF_AW = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            tx_data_i,
    input  logic                  tx_data_valid_i,
    input  logic [1:0]            tx_chl_i,
    output logic                  tx_busy_o,
    output logic [7:0]            rx_data_o,
    output logic                  rx_data_valid_o,
    output logic [1:0]            rx_chl_o,
    output logic                  tx_ovf_o,
    output logic                  bus_err_o,
    output logic                  lbus_tx_ready_o,
    input  logic                  lbus_en_i,
    input  logic [1:0]            lbus_op_i,
    inout  wire [LBUS_DAT_W-1:0]  lbus_dat_io
);

    logic       wrStrobe, rdStrobe, badStrobe;
    logic       push, pop;
    logic       full, empty, oneLeft;
    lbus_word_t pushWord, headWord;

    logic [7:0] rxData_q, rxData_d;
    logic [1:0] rxChl_q, rxChl_d;
    logic       rxValid_q, rxValid_d;
    logic       txOvf_q, txOvf_d;
    logic       busErr_q, busErr_d;

    assign wrStrobe  = lbus_en_i && (lbus_op_i == LBUS_OP_WR);
    assign rdStrobe  = lbus_en_i && (lbus_op_i == LBUS_OP_RD);
    assign badStrobe = lbus_en_i && (lbus_op_i == 2'b11);

    assign pop      = rdStrobe && !empty;
    assign push     = tx_data_valid_i && (!full || pop);
    assign pushWord = '{chl: tx_chl_i, data: tx_data_i};

    lbus_sync_fifo #(
        .AW (TXF_AW),
        .DW (LBUS_DAT_W)
    ) u_txFifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .wdata_i    (pushWord),
        .pop_i      (pop),
        .rdata_o    (headWord),
        .full_o     (full),
        .empty_o    (empty),
        .one_left_o (oneLeft)
    );

    // Drop ready while the last entry is being popped so the master never re-reads it.
    assign lbus_tx_ready_o = !empty && !(rdStrobe && oneLeft);
    assign tx_busy_o       = full;
    assign lbus_dat_io     = (!empty && (lbus_op_i != LBUS_OP_WR)) ? headWord
                                                                   : {LBUS_DAT_W{1'bz}};

    always_comb begin
        rxValid_d = wrStrobe;
        rxData_d  = wrStrobe ? lbus_dat_io[7:0] : rxData_q;
        rxChl_d   = wrStrobe ? lbus_dat_io[9:8] : rxChl_q;
        txOvf_d   = txOvf_q || (tx_data_valid_i && full && !pop);
        busErr_d  = busErr_q || (rdStrobe && empty) || badStrobe;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxData_q  <= '0;
            rxChl_q   <= '0;
            rxValid_q <= 1'b0;
            txOvf_q   <= 1'b0;
            busErr_q  <= 1'b0;
        end else begin
            rxData_q  <= rxData_d;
            rxChl_q   <= rxChl_d;
            rxValid_q <= rxValid_d;
            txOvf_q   <= txOvf_d;
            busErr_q  <= busErr_d;
        end
    end

    assign rx_data_o       = rxData_q;
    assign rx_chl_o        = rxChl_q;
    assign rx_data_valid_o = rxValid_q;
    assign tx_ovf_o        = txOvf_q;
    assign bus_err_o       = busErr_q;

endmodule

// File: tb/tb_local_bus_slave.sv
// Bench for local_bus_slave: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed expectations. An undriven bus reads as 10'h3FF.
module tb_local_bus_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic [1:0] tx_chl;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [1:0] rx_chl;
    logic       tx_ovf;
    logic       bus_err;
    logic       lbus_tx_ready;
    logic       lbus_en;
    logic [1:0] lbus_op;
    logic [9:0] mDat;
    wire  [9:0] lbus_dat;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [9:0] mq[$];
    bit         mOvf, mErr, mRxV;
    logic [7:0] mRxD;
    logic [1:0] mRxC;
    bit         rdM, popM, fullM;

    always #5 clk = ~clk;

    pullup (lbus_dat);
    assign lbus_dat = (lbus_op == 2'b01) ? mDat : 10'bz;

    local_bus_slave #(.TXF_AW(3)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .tx_data_i       (tx_data),
        .tx_data_valid_i (tx_data_valid),
        .tx_chl_i        (tx_chl),
        .tx_busy_o       (tx_busy),
        .rx_data_o       (rx_data),
        .rx_data_valid_o (rx_data_valid),
        .rx_chl_o        (rx_chl),
        .tx_ovf_o        (tx_ovf),
        .bus_err_o       (bus_err),
        .lbus_tx_ready_o (lbus_tx_ready),
        .lbus_en_i       (lbus_en),
        .lbus_op_i       (lbus_op),
        .lbus_dat_io     (lbus_dat)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] op, input logic [9:0] dat,
                                 input logic valid, input logic [7:0] txd, input logic [1:0] chl);
        @(posedge clk);
        #1;
        lbus_en       = en;
        lbus_op       = op;
        mDat          = dat;
        tx_data_valid = valid;
        tx_data       = txd;
        tx_chl        = chl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 10'h0, 1'b0, 8'h0, 2'd0);
    endtask

    task automatic pushByte(input logic [7:0] d, input logic [1:0] c);
        applyStimulus(1'b0, 2'b00, 10'h0, 1'b1, d, c);
    endtask

    task automatic readStrobe();
        applyStimulus(1'b1, 2'b10, 10'h0, 1'b0, 8'h0, 2'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        lbus_en = 1'b0; lbus_op = 2'b00; mDat = '0;
        tx_data_valid = 1'b0; tx_data = '0; tx_chl = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Reference model: FIFO as a queue, flags and RX capture from the bus rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mOvf = 0; mErr = 0; mRxV = 0; mRxD = '0; mRxC = '0;
        end else begin
            rdM   = lbus_en && (lbus_op == 2'b10);
            popM  = rdM && (mq.size() > 0);
            fullM = (mq.size() == 8);
            mRxV  = lbus_en && (lbus_op == 2'b01);
            if (mRxV) begin
                mRxC = lbus_dat[9:8];
                mRxD = lbus_dat[7:0];
            end
            if (rdM && mq.size() == 0) mErr = 1;
            if (lbus_en && lbus_op == 2'b11) mErr = 1;
            if (popM) void'(mq.pop_front());
            if (tx_data_valid) begin
                if (!fullM || popM) mq.push_back({tx_chl, tx_data});
                else mOvf = 1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [9:0] expBus;
        logic       expReady;
        if (lbus_op == 2'b01)   expBus = mDat;
        else if (mq.size() > 0) expBus = mq[0];
        else                    expBus = 10'h3FF;
        expReady = (mq.size() > 0) && !(lbus_en && lbus_op == 2'b10 && mq.size() == 1);
        checkOutput("m_tx_busy", tx_busy, mq.size() == 8);
        checkOutput("m_tx_ready", lbus_tx_ready, expReady);
        checkOutput("m_lbus_dat", lbus_dat, expBus);
        checkOutput("m_rx_valid", rx_data_valid, mRxV);
        checkOutput("m_rx_data", rx_data, mRxD);
        checkOutput("m_rx_chl", rx_chl, mRxC);
        checkOutput("m_tx_ovf", tx_ovf, mOvf);
        checkOutput("m_bus_err", bus_err, mErr);
    end

    initial begin
        logic [7:0] rd8;
        logic [1:0] rc;
        rst_n = 1'b0;
        lbus_en = 1'b0; lbus_op = 2'b00; mDat = '0;
        tx_data_valid = 1'b0; tx_data = '0; tx_chl = '0;

        @(negedge clk);
        checkOutput("rst_ready", lbus_tx_ready, 0);
        checkOutput("rst_busy", tx_busy, 0);
        checkOutput("rst_dat", lbus_dat, 10'h3FF);
        checkOutput("rst_rxv", rx_data_valid, 0);
        #2 rst_n = 1'b1;

        // Single push then a single read of the last entry
        pushByte(8'hA5, 2'd1);
        idle();
        @(negedge clk);
        checkOutput("rd1_ready", lbus_tx_ready, 1);
        checkOutput("rd1_dat", lbus_dat, 10'h1A5);
        readStrobe();
        @(negedge clk);
        checkOutput("rd1_ready_strobe", lbus_tx_ready, 0);
        checkOutput("rd1_dat_strobe", lbus_dat, 10'h1A5);
        idle();
        @(negedge clk);
        checkOutput("rd1_ready_after", lbus_tx_ready, 0);
        checkOutput("rd1_dat_after", lbus_dat, 10'h3FF);
        checkOutput("rd1_err", bus_err, 0);

        // Back-to-back master writes
        applyStimulus(1'b1, 2'b01, 10'h23C, 1'b0, 8'h0, 2'd0);
        applyStimulus(1'b1, 2'b01, 10'h0FF, 1'b0, 8'h0, 2'd0);
        @(negedge clk);
        checkOutput("wr1_valid", rx_data_valid, 1);
        checkOutput("wr1_data", rx_data, 8'h3C);
        checkOutput("wr1_chl", rx_chl, 2'd2);
        idle();
        @(negedge clk);
        checkOutput("wr2_valid", rx_data_valid, 1);
        checkOutput("wr2_data", rx_data, 8'hFF);
        checkOutput("wr2_chl", rx_chl, 2'd0);
        idle();
        @(negedge clk);
        checkOutput("wr_valid_end", rx_data_valid, 0);

        // Fill past full, then drain in order
        for (int i = 0; i < 9; i++) pushByte(8'(i), 2'd0);
        @(negedge clk);
        checkOutput("fill_busy", tx_busy, 1);
        checkOutput("fill_ovf_pre", tx_ovf, 0);
        idle();
        @(negedge clk);
        checkOutput("fill_ovf", tx_ovf, 1);
        for (int i = 0; i < 8; i++) begin
            readStrobe();
            @(negedge clk);
            checkOutput("drain_dat", lbus_dat, 10'(i));
        end
        idle();
        @(negedge clk);
        checkOutput("drain_ready", lbus_tx_ready, 0);
        checkOutput("drain_busy", tx_busy, 0);

        // Push and pop together while full
        doReset();
        for (int i = 0; i < 8; i++) pushByte(8'h10 + 8'(i), 2'd0);
        applyStimulus(1'b1, 2'b10, 10'h0, 1'b1, 8'h55, 2'd0);
        @(negedge clk);
        checkOutput("pp_busy", tx_busy, 1);
        checkOutput("pp_dat", lbus_dat, 10'h010);
        idle();
        @(negedge clk);
        checkOutput("pp_busy_after", tx_busy, 1);
        checkOutput("pp_ovf", tx_ovf, 0);
        checkOutput("pp_head", lbus_dat, 10'h011);
        for (int i = 0; i < 8; i++) begin
            readStrobe();
            @(negedge clk);
            checkOutput("pp_drain", lbus_dat, (i < 7) ? 10'h011 + 10'(i) : 10'h055);
        end

        // Illegal reads and reserved opcode
        doReset();
        readStrobe();
        @(negedge clk);
        checkOutput("err_dat", lbus_dat, 10'h3FF);
        idle();
        @(negedge clk);
        checkOutput("err_empty_rd", bus_err, 1);
        pushByte(8'h3C, 2'd2);
        idle();
        @(negedge clk);
        checkOutput("err_ptrs", lbus_dat, 10'h23C);
        doReset();
        applyStimulus(1'b1, 2'b11, 10'h0, 1'b0, 8'h0, 2'd0);
        @(negedge clk);
        checkOutput("op11_dat", lbus_dat, 10'h3FF);
        idle();
        @(negedge clk);
        checkOutput("op11_err", bus_err, 1);

        // Reset in the middle of a read with entries queued
        doReset();
        pushByte(8'h01, 2'd0);
        pushByte(8'h02, 2'd0);
        pushByte(8'h03, 2'd0);
        readStrobe();
        @(negedge clk);
        checkOutput("mid_ready", lbus_tx_ready, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_dat", lbus_dat, 10'h3FF);
        checkOutput("mid_rst_ready", lbus_tx_ready, 0);
        checkOutput("mid_rst_err", bus_err, 0);
        idle();
        #1 rst_n = 1'b1;
        pushByte(8'h77, 2'd0);
        idle();
        @(negedge clk);
        checkOutput("mid_head", lbus_dat, 10'h077);

        // Randomized traffic, checked by the model process
        doReset();
        for (int n = 0; n < 800; n++) begin
            rd8 = 8'($urandom);
            rc  = 2'($urandom);
            if ({rc, rd8} == 10'h3FF) rd8 = 8'hFE;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 10'($urandom),
                          ($urandom_range(0, 9) < 6), rd8, rc);
            if (n == 400) begin
                doReset();
            end
        end
        idle();
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
